// File: rtl/booth_controller_if.sv
// Control interface between the Booth sequencing controller and its datapath.
//   start     : system start request (into the controller)
//   x0, x1    : datapath status, current / previous Booth bit
//   ready     : controller idle
//   ldY..ldE  : datapath control strobes
//   osel      : result word select, 0 = A (high), 1 = X (low)
//   out_valid : result word on data_out
//   done      : final result word pulse
interface booth_controller_if;
  logic start;
  logic x0;
  logic x1;
  logic ready;
  logic ldY;
  logic ldX;
  logic clrA;
  logic clrE;
  logic ldA;
  logic sel;
  logic shA;
  logic shX;
  logic ldE;
  logic osel;
  logic out_valid;
  logic done;

  // Controller side: drives every strobe, reads start and the Booth bits.
  modport master (
    input  start, x0, x1,
    output ready, ldY, ldX, clrA, clrE, ldA, sel, shA, shX, ldE,
           osel, out_valid, done
  );

  // Datapath / system side.
  modport slave (
    output start, x0, x1,
    input  ready, ldY, ldX, clrA, clrE, ldA, sel, shA, shX, ldE,
           osel, out_valid, done
  );
endinterface

// File: rtl/booth_controller.sv
// Sequencing controller for the radix-2 Booth multiplier datapath.
// Steps the datapath through operand load, N add/subtract + shift
// iterations and a two-word result readout, then pulses done.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : booth_controller_if.master (start/x0/x1 in, strobes out)
// Parameters: N = operand width / iteration count, CW = counter width
// (2**CW must exceed N).
module booth_controller #(
  parameter int unsigned N  = 5,
  parameter int unsigned CW = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_controller_if.master   bus
);

  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_LOAD_X,
    S_CHECK,
    S_SHIFT,
    S_OUT_HI,
    S_OUT_LO
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic w_ready;
  logic w_ldY;
  logic w_ldX;
  logic w_clrA;
  logic w_clrE;
  logic w_ldA;
  logic w_sel;
  logic w_shA;
  logic w_shX;
  logic w_ldE;
  logic w_osel;
  logic w_out_valid;
  logic w_done;

  // State and iteration counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and strobe decode. Strobes decode straight from the state
  // register so that an asynchronous reset clears them without waiting for
  // a clock edge; CHECK additionally looks at the live Booth bits.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    w_ldY       = 1'b0;
    w_ldX       = 1'b0;
    w_clrA      = 1'b0;
    w_clrE      = 1'b0;
    w_ldA       = 1'b0;
    w_sel       = 1'b0;
    w_shA       = 1'b0;
    w_shX       = 1'b0;
    w_ldE       = 1'b0;
    w_osel      = 1'b0;
    w_out_valid = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.start) w_state_nxt = S_LOAD_Y;
      end
      S_LOAD_Y: begin
        w_ldY       = 1'b1;
        w_clrA      = 1'b1;
        w_clrE      = 1'b1;
        w_state_nxt = S_LOAD_X;
      end
      S_LOAD_X: begin
        w_ldX       = 1'b1;
        w_cnt_nxt   = CNT_INIT;
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // {x0,x1} = 10 starts a run of ones (subtract), 01 ends one (add).
        if (bus.x0 && !bus.x1) begin
          w_ldA = 1'b1;
          w_sel = 1'b1;
        end else if (!bus.x0 && bus.x1) begin
          w_ldA = 1'b1;
        end
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_shA       = 1'b1;
        w_shX       = 1'b1;
        w_ldE       = 1'b1;
        w_cnt_nxt   = r_cnt - CNT_ONE;
        // Counter value 1 here means this is the last iteration's shift.
        w_state_nxt = (r_cnt == CNT_ONE) ? S_OUT_HI : S_CHECK;
      end
      S_OUT_HI: begin
        w_out_valid = 1'b1;
        w_state_nxt = S_OUT_LO;
      end
      S_OUT_LO: begin
        w_osel      = 1'b1;
        w_out_valid = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.ready     = w_ready;
  assign bus.ldY       = w_ldY;
  assign bus.ldX       = w_ldX;
  assign bus.clrA      = w_clrA;
  assign bus.clrE      = w_clrE;
  assign bus.ldA       = w_ldA;
  assign bus.sel       = w_sel;
  assign bus.shA       = w_shA;
  assign bus.shX       = w_shX;
  assign bus.ldE       = w_ldE;
  assign bus.osel      = w_osel;
  assign bus.out_valid = w_out_valid;
  assign bus.done      = w_done;

endmodule

// File: tb/tb_booth_controller.sv
// Self-checking bench for booth_controller: a simple 5-bit datapath model
// answers the controller's strobes; strobe sequences are checked cycle by
// cycle against a schedule derived from the Booth recoding rules, and result
// words against the signed product.
module tb_booth_controller;

  localparam int N = 5;

  logic clk;
  logic rst_n;

  booth_controller_if bif ();

  booth_controller #(.N(5), .CW(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model.
  logic [4:0] op_y, op_x;
  logic [4:0] dp_y, dp_a, dp_x;
  logic       dp_e;
  logic       force11;
  logic [4:0] data_in, data_out;

  assign data_in  = bif.ldY ? op_y : op_x;
  assign data_out = bif.osel ? dp_x : dp_a;
  assign bif.x0   = force11 ? 1'b1 : dp_x[0];
  assign bif.x1   = force11 ? 1'b1 : dp_e;

  always @(posedge clk) begin
    if (bif.ldY)  dp_y <= data_in;
    if (bif.clrA) dp_a <= '0;
    if (bif.clrE) dp_e <= 1'b0;
    if (bif.ldX)  dp_x <= data_in;
    if (bif.ldA)  dp_a <= bif.sel ? (dp_a - dp_y) : (dp_a + dp_y);
    if (bif.shA)  dp_a <= {dp_a[4], dp_a[4:1]};
    if (bif.shX)  dp_x <= {dp_a[0], dp_x[4:1]};
    if (bif.ldE)  dp_e <= dp_x[0];
  end

  int n_vec = 0;
  int n_err = 0;

  // {ready,ldY,ldX,clrA,clrE,ldA,sel,shA,shX,ldE,osel,out_valid,done}
  localparam logic [12:0] V_IDLE = 13'b1_0000_0000_0000;

  function automatic logic [12:0] dut_vec();
    return {bif.ready, bif.ldY, bif.ldX, bif.clrA, bif.clrE, bif.ldA, bif.sel,
            bif.shA, bif.shX, bif.ldE, bif.osel, bif.out_valid, bif.done};
  endfunction

  // Expected strobes k cycles after start was sampled, from Booth recoding
  // of the multiplier: iteration i looks at the pair (X[i], X[i-1]), X[-1]=0.
  function automatic logic [12:0] exp_vec(int k, logic [4:0] x, bit f11);
    logic [12:0] v;
    int          i;
    logic        cur, prev;
    v = '0;
    if (k == 1) begin
      v[11] = 1'b1; v[9] = 1'b1; v[8] = 1'b1;
    end else if (k == 2) begin
      v[10] = 1'b1;
    end else if (k >= 3 && k <= 2*N+2) begin
      if ((k % 2) == 1) begin
        i   = (k - 3) / 2;
        cur = x[i];
        if (i == 0) prev = 1'b0;
        else        prev = x[i-1];
        if (f11) begin
          cur  = 1'b1;
          prev = 1'b1;
        end
        v[7] = cur ^ prev;
        v[6] = cur & ~prev;
      end else begin
        v[5] = 1'b1; v[4] = 1'b1; v[3] = 1'b1;
      end
    end else if (k == 2*N+3) begin
      v[1] = 1'b1;
    end else if (k == 2*N+4) begin
      v[2] = 1'b1; v[1] = 1'b1; v[0] = 1'b1;
    end else begin
      v = V_IDLE;
    end
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // One full operation; entered at a negedge with the controller in IDLE.
  task automatic run_op(input logic [4:0] y, input logic [4:0] x, input bit f11,
                        input bit hold, input bit pulses, input bit chk_data,
                        input logic [4:0] ehi, input logic [4:0] elo);
    int done_cnt;
    done_cnt  = 0;
    op_y      = y;
    op_x      = x;
    force11   = f11;
    bif.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 2*N+5; k++) begin
      @(negedge clk);
      check($sformatf("strobes y=%b x=%b k=%0d", y, x, k), 16'(dut_vec()), 16'(exp_vec(k, x, f11)));
      if (bif.done) done_cnt++;
      if (chk_data && k == 2*N+3) check($sformatf("hi %0dx%0d", $signed(y), $signed(x)), 16'(data_out), 16'(ehi));
      if (chk_data && k == 2*N+4) check($sformatf("lo %0dx%0d", $signed(y), $signed(x)), 16'(data_out), 16'(elo));
      if (hold) bif.start = 1'b1;
      else      bif.start = pulses && (k == 5 || k == 9);
    end
    check("done_count", 16'(done_cnt), 16'd1);
    force11 = 1'b0;
  endtask

  typedef struct {
    logic [4:0] y;
    logic [4:0] x;
    bit         f11;
    logic [4:0] hi;
    logic [4:0] lo;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [4:0]        y, x;
    logic signed [9:0] ys, xs, p;

    tbl[0] = '{y: 5'b01010, x: 5'b01101, f11: 1'b0, hi: 5'b00100, lo: 5'b00010}; // 10*13
    tbl[1] = '{y: 5'b11101, x: 5'b00111, f11: 1'b0, hi: 5'b11111, lo: 5'b01011}; // -3*7
    tbl[2] = '{y: 5'b01010, x: 5'b00000, f11: 1'b0, hi: 5'b00000, lo: 5'b00000}; // X=0
    tbl[3] = '{y: 5'b01111, x: 5'b01111, f11: 1'b0, hi: 5'b00111, lo: 5'b00001}; // 15*15
    tbl[4] = '{y: 5'b01111, x: 5'b10000, f11: 1'b0, hi: 5'b11000, lo: 5'b10000}; // 15*-16
    tbl[5] = '{y: 5'b00110, x: 5'b10101, f11: 1'b1, hi: 5'b00000, lo: 5'b00000}; // forced 11

    bif.start = 1'b0;
    force11   = 1'b0;
    op_y      = '0;
    op_x      = '0;
    rst_n     = 1'b0;
    #23;
    check("reset_state", 16'(dut_vec()), 16'(V_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 16'(dut_vec()), 16'(V_IDLE));

    // Table vectors.
    for (int t = 0; t < 6; t++)
      run_op(tbl[t].y, tbl[t].x, tbl[t].f11, 1'b0, 1'b0, !tbl[t].f11, tbl[t].hi, tbl[t].lo);

    // start pulses mid-operation must be ignored.
    run_op(5'b01010, 5'b01101, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00100, 5'b00010);

    // start held high: back-to-back operations with one IDLE cycle each.
    run_op(5'b11101, 5'b00111, 1'b0, 1'b1, 1'b0, 1'b1, 5'b11111, 5'b01011);
    run_op(5'b11101, 5'b00111, 1'b0, 1'b1, 1'b0, 1'b1, 5'b11111, 5'b01011);
    run_op(5'b01010, 5'b01101, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00100, 5'b00010);

    // Asynchronous reset during SHIFT.
    op_y      = 5'b01010;
    op_x      = 5'b01101;
    bif.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bif.start = 1'b0;
      check($sformatf("pre_reset k=%0d", k), 16'(dut_vec()), 16'(exp_vec(k, op_x, 1'b0)));
    end
    #1 rst_n = 1'b0;
    #1 check("async_reset_strobes", 16'(dut_vec()), 16'(V_IDLE));
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_abort", 16'(dut_vec()), 16'(V_IDLE));
    run_op(5'b01010, 5'b01101, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00100, 5'b00010);

    // Randomized operands against the signed product.
    for (int r = 0; r < 20; r++) begin
      do y = 5'($urandom); while (y == 5'b10000);
      x  = 5'($urandom);
      ys = {{5{y[4]}}, y};
      xs = {{5{x[4]}}, x};
      p  = ys * xs;
      run_op(y, x, 1'b0, 1'b0, 1'b0, 1'b1, p[9:5], p[4:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth_controller.md
# booth_controller

Sequencing controller for the 5-bit radix-2 Booth multiplier: the initiating end of the datapath control interface. It accepts a start request, steps the datapath through operand load, N add/subtract-and-shift iterations and two-word result readout, and signals completion. It reads two status bits back from the datapath and drives every datapath control strobe. It sits between the system-level start/done handshake and the `datapath` instance.

## Interface
- `N`, default 5: operand width; the iteration count equals `N`.
- `CW`, default 3: iteration counter width; must satisfy 2^CW > N.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiplication; sampled only in IDLE.
- `x0`  in  1  datapath X register LSB, current Booth bit.
- `x1`  in  1  datapath E flip-flop, previous Booth bit.
- `ready`  out  1  high only in IDLE.
- `ldY`, `ldX`  out  1  load multiplicand / multiplier from `data_in`.
- `clrA`, `clrE`  out  1  clear accumulator / E flip-flop.
- `ldA`  out  1  load A with the adder/subtractor result.
- `sel`  out  1  ALU op: 1 = A−Y, 0 = A+Y.
- `shA`, `shX`  out  1  arithmetic right shift of the {A,X} pair.
- `ldE`  out  1  E ← X[0], captured on the same edge as the shift.
- `osel`  out  1  result mux: 0 = A (high word), 1 = X (low word).
- `out_valid`  out  1  `data_out` holds a result word.
- `done`  out  1  one-cycle pulse with the final word.

## Operation
- Reset is asynchronous and active-low.
- On reset, the state is IDLE and the counter is 0. `ready` = 1; all other outputs = 0.
- States and transitions:
  - IDLE → LOAD_Y when `start` = 1; otherwise remain in IDLE.
  - LOAD_Y → LOAD_X.
  - LOAD_X → CHECK.
  - CHECK → SHIFT.
  - SHIFT → CHECK when the counter ≠ 1; SHIFT → OUT_HI when the counter = 1.
  - OUT_HI → OUT_LO.
  - OUT_LO → IDLE.
- LOAD_Y asserts `ldY`, `clrA` and `clrE`. The source must present Y on `data_in` during this cycle.
- LOAD_X asserts `ldX` and loads the counter with `N`. The source must present X on `data_in` during this cycle.
- CHECK decodes {x0,x1}; outputs are combinational from the state and these inputs:
  - 10 → `ldA` = 1, `sel` = 1 (subtract).
  - 01 → `ldA` = 1, `sel` = 0 (add).
  - 00 or 11 → `ldA` = 0, `sel` = 0.
- SHIFT asserts `shA`, `shX` and `ldE` together, and decrements the counter.
- OUT_HI drives `osel` = 0 and `out_valid` = 1.
- OUT_LO drives `osel` = 1, `out_valid` = 1 and `done` = 1.
- In every state, any strobe not listed for that state is 0.
- `ldA` and the shift strobes are never asserted in the same cycle. `ldY`/`ldX` are never asserted outside LOAD_Y/LOAD_X.
- `start` is ignored outside IDLE. It is not queued.
- `start` held high through OUT_LO starts a new operation: the cycle after OUT_LO is IDLE, which samples `start` and moves to LOAD_Y on the following cycle.
- Reset asserted mid-operation returns the block to IDLE immediately, with all strobes at 0. No `done` is produced for the aborted operation.

## Timing
- Cycle 0: IDLE samples `start` = 1.
- Cycle 1: LOAD_Y.
- Cycle 2: LOAD_X.
- Cycles 3 to 2N+2: alternating CHECK and SHIFT.
- Cycle 2N+3: OUT_HI.
- Cycle 2N+4: OUT_LO, with `done` = 1.
- With N = 5: `done` is seen 14 cycles after `start` is sampled, and `ready` returns at cycle 15.
- Every iteration takes exactly 2 cycles, whether or not an add/subtract occurs. Latency is data-independent.
- The counter is never 0 in CHECK or SHIFT. It reaches 0 on the last SHIFT edge.

## Test plan
- Reset during SHIFT (`rst_n` low for 3 ns, asynchronous) → `ready` = 1 and every strobe 0 before the next clock edge. A fresh `start` afterwards produces a normal 15-cycle sequence.
- With the datapath, Y = 01010, X = 01101 (10 × 13) → first CHECK has `ldA` = 1, `sel` = 1. OUT_HI `data_out` = 00100, OUT_LO `data_out` = 00010 (130). `done` occurs at cycle 14.
- With the datapath, Y = 11101, X = 00111 (−3 × 7) → OUT_HI = 11111, OUT_LO = 01011 (−21). Exactly 2 CHECK cycles have `ldA` = 1: the first is a subtract, and the one at iteration 4 is an add.
- X = 00000 → `ldA` never asserted, 5 SHIFT cycles, result 00000/00000. The cycle count is identical to the 10 × 13 case.
- `start` pulsed at cycles 5 and 9 of a running operation → both pulses ignored, exactly one `done`. `start` held high continuously → `done` every 15 cycles, with exactly one IDLE cycle between operations.
- Force x0 = 1, x1 = 1 in every CHECK → `ldA` = 0 throughout. `shA`/`shX`/`ldE` each go high in exactly 5 cycles.
